// File: rtl/mc_control_if.sv
// Control bundle between the multi-cycle main controller and the datapath.
// The controller takes the master view; the datapath/IR side takes the slave view.
interface mc_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegWrite;
  logic       RegDst;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic [1:0] ALUop;
  logic [3:0] state;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource,
           ALUop, state, instr_done, illegal
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource,
           ALUop, state, instr_done, illegal
  );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle MIPS main control FSM: sequences one instruction over 2-5 cycles
// and drives every datapath enable/select combinationally from the state.
module mc_control (
  input  logic         clk,
  input  logic         rst_n,
  mc_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal;
  } ctl_t;

  state_e state_q;
  state_e state_d;
  ctl_t   ctl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    ctl     = '0;
    case (state_q)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = 2'b01;
        ctl.ir_write  = bus.mem_ready;
        ctl.pc_write  = bus.mem_ready;
        state_d       = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // ALU precomputes the branch target while the opcode is decoded
        ctl.alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_I_EXEC;
          default: begin
            ctl.illegal    = 1'b1;
            ctl.instr_done = 1'b1;
            state_d        = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        state_d       = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
        state_d      = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        ctl.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEM_WRITE: begin
        ctl.mem_write  = 1'b1;
        ctl.iord       = 1'b1;
        ctl.instr_done = bus.mem_ready;
        state_d        = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_R_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = 2'b10;
        state_d       = S_R_WB;
      end
      S_R_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = 1'b1;
        ctl.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_op        = 2'b01;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = 2'b01;
        ctl.instr_done    = 1'b1;
        state_d           = S_FETCH;
      end
      S_JUMP: begin
        ctl.pc_write   = 1'b1;
        ctl.pc_source  = 2'b10;
        ctl.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_I_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        state_d       = S_I_WB;
      end
      S_I_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset kills every strobe at once, without waiting for a clock edge
    if (!rst_n) begin
      ctl = '0;
    end
  end

  assign bus.PCWrite     = ctl.pc_write;
  assign bus.PCWriteCond = ctl.pc_write_cond;
  assign bus.IorD        = ctl.iord;
  assign bus.MemRead     = ctl.mem_read;
  assign bus.MemWrite    = ctl.mem_write;
  assign bus.IRWrite     = ctl.ir_write;
  assign bus.MemtoReg    = ctl.mem_to_reg;
  assign bus.RegWrite    = ctl.reg_write;
  assign bus.RegDst      = ctl.reg_dst;
  assign bus.ALUSrcA     = ctl.alu_src_a;
  assign bus.ALUSrcB     = ctl.alu_src_b;
  assign bus.PCSource    = ctl.pc_source;
  assign bus.ALUop       = ctl.alu_op;
  assign bus.instr_done  = ctl.instr_done;
  assign bus.illegal     = ctl.illegal;
  assign bus.state       = rst_n ? state_q : S_FETCH;

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: directed scenarios with literal expectations plus a
// randomized run checked every cycle against an instruction-plan model.
module tb_mc_control;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic [3:0] state;
    logic       instr_done;
    logic       illegal;
  } ctl_t;

  logic clk;
  logic rst_n;
  mc_control_if bus ();

  mc_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ctl_t dut_ctl;
  assign dut_ctl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                    bus.IRWrite, bus.MemtoReg, bus.RegWrite, bus.RegDst, bus.ALUSrcA,
                    bus.ALUSrcB, bus.PCSource, bus.ALUop, bus.state, bus.instr_done,
                    bus.illegal};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit legal_op(input logic [5:0] op);
    return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
           op == 6'b000100 || op == 6'b000010 || op == 6'b001000;
  endfunction

  // Required controls for a state, straight from the per-state rules
  function automatic ctl_t exp_ctl(input int st, input logic mr, input logic [5:0] op);
    ctl_t e;
    e = '0;
    e.state = 4'(st);
    case (st)
      0:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = mr; e.pc_write = mr; end
      1:  begin e.alu_src_b = 2'b11; e.illegal = !legal_op(op); e.instr_done = !legal_op(op); end
      2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      3:  begin e.mem_read = 1; e.iord = 1; end
      4:  begin e.reg_write = 1; e.mem_to_reg = 1; e.instr_done = 1; end
      5:  begin e.mem_write = 1; e.iord = 1; e.instr_done = mr; end
      6:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      7:  begin e.reg_write = 1; e.reg_dst = 1; e.instr_done = 1; end
      8:  begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1;
                e.pc_source = 2'b01; e.instr_done = 1; end
      9:  begin e.pc_write = 1; e.pc_source = 2'b10; e.instr_done = 1; end
      10: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      11: begin e.reg_write = 1; e.instr_done = 1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  // Model: an instruction is FETCH, DECODE, then an opcode-specific tail of states
  int plan[$];
  int pidx;
  int cur;
  bit stall;

  task automatic plan_restart();
    plan.delete();
    plan.push_back(0);
    plan.push_back(1);
    pidx = 0;
  endtask

  task automatic plan_tail(input logic [5:0] op);
    case (op)
      6'b100011: begin plan.push_back(2); plan.push_back(3); plan.push_back(4); end
      6'b101011: begin plan.push_back(2); plan.push_back(5); end
      6'b000000: begin plan.push_back(6); plan.push_back(7); end
      6'b000100: plan.push_back(8);
      6'b000010: plan.push_back(9);
      6'b001000: begin plan.push_back(10); plan.push_back(11); end
      default: ;
    endcase
  endtask

  initial plan_restart();

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs", 32'(dut_ctl), 32'(0));
      plan_restart();
    end else begin
      cur = plan[pidx];
      check($sformatf("cycle_st%0d", cur), 32'(dut_ctl),
            32'(exp_ctl(cur, bus.mem_ready, bus.opcode)));
      stall = (cur == 0 || cur == 3 || cur == 5) && !bus.mem_ready;
      if (!stall) begin
        if (cur == 1) plan_tail(bus.opcode);
        pidx++;
        if (pidx >= plan.size()) plan_restart();
      end
    end
  end

  ctl_t log_q[$];

  task automatic step(input logic mr);
    bus.mem_ready = mr;
    @(negedge clk);
    log_q.push_back(dut_ctl);
    @(posedge clk);
    #1;
  endtask

  task automatic check_states(input string name, input int exp[$]);
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s_state%0d", name, i), 32'(log_q[i].state), 32'(exp[i]));
  endtask

  int cnt;
  int exp_seq[$];
  logic lw_mr[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [5:0] ops[6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};

  initial begin
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    bus.opcode = 6'b000000;
    @(posedge clk);
    #1;

    // Reset held for three cycles
    log_q.delete();
    for (int i = 0; i < 3; i++) step(1'b1);
    for (int i = 0; i < 3; i++) check("rst_vec", 32'(log_q[i]), 32'(0));
    rst_n = 1'b1;

    // R-type, no stall
    log_q.delete();
    bus.opcode = 6'b000000;
    for (int i = 0; i < 4; i++) step(1'b1);
    check("first_memread", 32'(log_q[0].mem_read), 32'(1));
    check("first_srcb", 32'(log_q[0].alu_src_b), 32'(1));
    exp_seq = '{0, 1, 6, 7};
    check_states("r", exp_seq);
    check("r_aluop", 32'(log_q[2].alu_op), 32'(2));
    check("r_regwrite", 32'({log_q[3].reg_write, log_q[3].reg_dst}), 32'(3));
    cnt = 0;
    foreach (log_q[i]) cnt += int'(log_q[i].instr_done);
    check("r_done_cnt", 32'(cnt), 32'(1));
    check("r_done_last", 32'(log_q[3].instr_done), 32'(1));

    // lw with two FETCH stalls and one MEM_READ stall: 8 cycles
    log_q.delete();
    bus.opcode = 6'b100011;
    for (int i = 0; i < 8; i++) step(lw_mr[i]);
    exp_seq = '{0, 0, 0, 1, 2, 3, 3, 4};
    check_states("lw", exp_seq);
    cnt = 0;
    foreach (log_q[i]) cnt += int'(log_q[i].ir_write);
    check("lw_irwrite_cnt", 32'(cnt), 32'(1));
    check("lw_wb", 32'({log_q[7].mem_to_reg, log_q[7].reg_write}), 32'(3));

    // sw, beq, j back to back
    log_q.delete();
    bus.opcode = 6'b101011;
    for (int i = 0; i < 4; i++) step(1'b1);
    exp_seq = '{0, 1, 2, 5};
    check_states("sw", exp_seq);
    cnt = 0;
    foreach (log_q[i]) cnt += int'(log_q[i].mem_write);
    check("sw_memwrite_cnt", 32'(cnt), 32'(1));

    log_q.delete();
    bus.opcode = 6'b000100;
    for (int i = 0; i < 3; i++) step(1'b1);
    exp_seq = '{0, 1, 8};
    check_states("beq", exp_seq);
    check("beq_ctl", 32'({log_q[2].pc_write_cond, log_q[2].alu_op}), 32'(3'b101));

    log_q.delete();
    bus.opcode = 6'b000010;
    for (int i = 0; i < 3; i++) step(1'b1);
    exp_seq = '{0, 1, 9};
    check_states("j", exp_seq);
    check("j_pcsource", 32'(log_q[2].pc_source), 32'(2));

    // Illegal opcode
    log_q.delete();
    bus.opcode = 6'b111111;
    for (int i = 0; i < 2; i++) step(1'b1);
    exp_seq = '{0, 1};
    check_states("ill", exp_seq);
    check("ill_flags", 32'({log_q[1].illegal, log_q[1].instr_done}), 32'(3));
    cnt = 0;
    foreach (log_q[i]) cnt += int'(log_q[i].reg_write) + int'(log_q[i].mem_write);
    check("ill_no_write", 32'(cnt), 32'(0));

    // Reset in the middle of a stalled store
    log_q.delete();
    bus.opcode = 6'b101011;
    for (int i = 0; i < 3; i++) step(1'b1);
    step(1'b0);
    check("ill_return", 32'(log_q[0].state), 32'(0));
    check("mr_in_write", 32'(log_q[3].state), 32'(5));
    #2;
    check("mr_memwrite_before", 32'(bus.MemWrite), 32'(1));
    rst_n = 1'b0;
    #1;
    check("mr_memwrite_async", 32'(bus.MemWrite), 32'(0));
    check("mr_state_async", 32'(bus.state), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    log_q.delete();
    bus.opcode = 6'b000000;
    step(1'b1);
    check("mr_after_state", 32'(log_q[0].state), 32'(0));
    check("mr_after_fetch", 32'(log_q[0].mem_read), 32'(1));

    // Randomized traffic; opcode only changes while the model is in FETCH
    for (int c = 0; c < 3000; c++) begin
      if (plan[pidx] == 0 && pidx == 0) begin
        if ($urandom_range(0, 7) == 0) bus.opcode = 6'($urandom);
        else bus.opcode = ops[$urandom_range(0, 5)];
      end
      bus.mem_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
